// File: rtl/alu_exec_unit.sv
// RV32IM-style execute unit: single-cycle base ops, a multi-cycle shift-add multiplier
// and a restoring divider, with a valid/ready handshake on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             op5,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_ILL
  } op_t;

  state_t           state, state_n;
  op_t              op_q, op_n, dec;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             illegal_q, illegal_n;

  logic [WIDTH-1:0] base_r;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

  // NOTE: every variable written in a combinational block gets a default first, so no latches.
  always_comb begin
    dec = OP_ILL;
    case (ALUOp)
      2'b00: dec = OP_ADD;
      2'b01: dec = OP_SUB;
      2'b10: begin
        if (op5 && funct7_0) begin
          case (funct3)
            3'b000:  dec = OP_MUL;
            3'b011:  dec = OP_MULHU;
            3'b101:  dec = OP_DIVU;
            3'b111:  dec = OP_REMU;
            default: dec = OP_ILL;
          endcase
        end else begin
          case (funct3)
            3'b000:  dec = (op5 && funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  dec = OP_SLL;
            3'b010:  dec = OP_SLT;
            3'b011:  dec = OP_SLTU;
            3'b100:  dec = OP_XOR;
            3'b101:  dec = funct7_5 ? OP_SRA : OP_SRL;
            3'b110:  dec = OP_OR;
            default: dec = OP_AND;
          endcase
        end
      end
      default: dec = OP_ILL;
    endcase
  end

  assign shamt = b[SW-1:0];

  // Single-cycle results, including the divide-by-zero shortcuts.
  always_comb begin
    base_r = '0;
    case (dec)
      OP_ADD:  base_r = a + b;
      OP_SUB:  base_r = a - b;
      OP_SLL:  base_r = a << shamt;
      OP_SLT:  base_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  base_r = a ^ b;
      OP_SRL:  base_r = a >> shamt;
      OP_SRA:  base_r = WIDTH'($signed(a) >>> shamt);
      OP_OR:   base_r = a | b;
      OP_AND:  base_r = a & b;
      OP_DIVU: base_r = '1;
      OP_REMU: base_r = a;
      default: base_r = '0;
    endcase
  end

  // One shift-add step: {hi,lo} holds the partial product, lo also shifts out the multiplier.
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

  // One restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo[WIDTH-2:0], div_ge};

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    a_n       = a_q;
    b_n       = b_q;
    hi_n      = hi;
    lo_n      = lo;
    cnt_n     = cnt;
    result_n  = result_q;
    illegal_n = illegal_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_n  = dec;
          a_n   = a;
          b_n   = b;
          hi_n  = '0;
          cnt_n = '0;
          if (dec == OP_MUL || dec == OP_MULHU) begin
            lo_n    = b;
            state_n = MUL;
          end else if ((dec == OP_DIVU || dec == OP_REMU) && b != '0) begin
            lo_n    = a;
            state_n = DIV;
          end else begin
            result_n  = base_r;
            illegal_n = (dec == OP_ILL);
            state_n   = DONE;
          end
        end
      end
      MUL: begin
        hi_n  = mul_hi_n;
        lo_n  = mul_lo_n;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          result_n  = (op_q == OP_MULHU) ? mul_hi_n : mul_lo_n;
          illegal_n = 1'b0;
          state_n   = DONE;
        end
      end
      DIV: begin
        hi_n  = div_hi_n;
        lo_n  = div_lo_n;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          result_n  = (op_q == OP_REMU) ? div_hi_n : div_lo_n;
          illegal_n = 1'b0;
          state_n   = DONE;
        end
      end
      default: begin
        if (out_ready) state_n = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: the datapath registers are reset as well because result must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_ILL;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      a_q       <= a_n;
      b_q       <= b_n;
      hi        <= hi_n;
      lo        <= lo_n;
      cnt       <= cnt_n;
      result_q  <= result_n;
      illegal_q <= illegal_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits (legal values 8, 16, 32, 64).
REQ-002 The block SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have in_valid  input  1  operation request.
REQ-005 The block SHALL have in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have ALUOp  input  2  main-decoder op class.
REQ-007 The block SHALL have funct3  input  3  instruction funct3.
REQ-008 The block SHALL have funct7_5  input  1  instruction bit 30.
REQ-009 The block SHALL have funct7_0  input  1  instruction bit 25 (M-extension select).
REQ-010 The block SHALL have op5  input  1  opcode bit 5 (1 = R-type).
REQ-011 The block SHALL have a, b  input  WIDTH each  operands.
REQ-012 The block SHALL have out_valid  output  1  result available.
REQ-013 The block SHALL have out_ready  input  1  consumer accepts result.
REQ-014 The block SHALL have result  output  WIDTH  operation result.
REQ-015 The block SHALL have zero  output  1  result == 0.
REQ-016 The block SHALL have illegal  output  1  unsupported encoding flag, qualified by out_valid.

Function
REQ-017 Decode SHALL be: ALUOp 00 -> ADD; 01 -> SUB; 11 -> illegal; 10 -> funct3 decode below.
REQ-018 ALUOp 10, M-ext (op5=1, funct7_0=1): funct3 000 MUL (low WIDTH bits), 011 MULHU (high WIDTH bits, unsigned), 101 DIVU, 111 REMU; other funct3 SHALL be illegal.
REQ-019 ALUOp 10, base: funct3 000 SUB if op5&funct7_5 else ADD; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRA if funct7_5 else SRL; 110 OR; 111 AND.
REQ-020 Shifts SHALL use b[$clog2(WIDTH)-1:0] as amount; SLT/SLTU SHALL return 1 or 0 zero-extended; ADD/SUB wrap modulo 2^WIDTH.
REQ-021 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-022 Transfer SHALL occur on a clock edge with in_valid & in_ready; inputs while in_ready=0 SHALL be ignored; operands and op latched at transfer.
REQ-023 Base ops, illegal ops and divide-by-zero: IDLE -> DONE; out_valid rises the cycle after transfer (latency 1).
REQ-024 MUL/MULHU: IDLE -> MUL, WIDTH iterations of radix-2 shift-add (2*WIDTH-bit product), then DONE; out_valid rises WIDTH+1 cycles after transfer.
REQ-025 DIVU/REMU, b != 0: IDLE -> DIV, WIDTH iterations restoring division, then DONE; out_valid latency WIDTH+1.
REQ-026 Divide by zero: DIVU SHALL return all ones, REMU SHALL return a; illegal = 0.
REQ-027 Illegal op: result = 0, zero = 1, illegal = 1.
REQ-028 DONE SHALL hold result, zero, illegal, out_valid stable until out_valid & out_ready, then go to IDLE next edge (out_valid low); new transfer earliest the edge after.
REQ-029 Iteration counter SHALL be $clog2(WIDTH)+1 bits and reach exactly WIDTH; no early termination.
REQ-030 zero SHALL be computed from the registered result.

Reset
REQ-031 rst asserted at any time, including mid-MUL/DIV or in DONE, SHALL immediately force IDLE, abort operation, and drive out_valid=0, result=0, zero=1, illegal=0, in_ready=1 while rst=1 and after release.
REQ-032 First transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 WIDTH=32, ALUOp=10, funct3=000, op5=1, funct7_5=1, a=5, b=7 -> one cycle later out_valid=1, result=0xFFFFFFFE, zero=0.
REQ-034 funct3=101, funct7_5=1, a=0x80000000, b=0x24 -> result=0xF8000000 (shift amount 4).
REQ-035 M-ext MULHU, a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after transfer, result=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-036 DIVU a=100,b=7 -> result=14 at latency 33; REMU same -> 2; DIVU b=0 -> 0xFFFFFFFF at latency 1; REMU b=0,a=9 -> 9.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while toggling inputs/in_valid -> outputs stable, in_ready=0, no transfer; then out_ready=1 -> IDLE next edge.
REQ-038 Assert rst 10 cycles into a DIVU -> out_valid=0, in_ready=1 immediately; ALUOp=11 after release -> illegal=1, result=0, zero=1.
